// File: rtl/instr_encoder.sv
// instr_encoder
//   Packs decoded RV32I fields (format, opcode, registers, funct fields and a
//   flat 32-bit immediate) into an instruction word and writes it into
//   instruction memory at an auto-incrementing word address. Immediates that
//   the selected format cannot encode are rejected with an error code.
//   A one-entry output buffer sits between the field input and the memory port.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   clear                    restart the load sequence at BASE_ADDR
//   in_valid / in_ready      field bundle handshake
//   in_fmt                   0=R 1=I 2=S 3=B 4=U 5=J (6,7 illegal)
//   in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm
//   mem_we / mem_ready       memory write handshake
//   mem_addr, mem_wdata      buffered write address and packed word
//   err, err_code            one-cycle reject pulse, sticky code (1=range,
//                            2=alignment, 3=illegal format)
//   count                    legal words accepted since reset/clear
//   full                     top address written, no further accepts
module instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   count,
  output logic              full
);

  localparam logic [ADDR_W-1:0] PTR_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  logic [ADDR_W-1:0] wr_ptr;
  logic [31:0]       packed_word;
  logic [1:0]        chk_code;
  logic              accept;
  logic              sext_is;
  logic              sext_b;
  logic              sext_j;

  assign in_ready = !full && !clear && (!mem_we || mem_ready);
  assign accept   = in_valid && in_ready;

  // An immediate fits its field when every bit above the field's sign bit
  // matches that sign bit.
  assign sext_is = (&in_imm[31:11]) || !(|in_imm[31:11]);
  assign sext_b  = (&in_imm[31:12]) || !(|in_imm[31:12]);
  assign sext_j  = (&in_imm[31:20]) || !(|in_imm[31:20]);

  always_comb begin
    packed_word = 32'd0;
    case (in_fmt)
      FMT_R: packed_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      FMT_I: packed_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      FMT_S: packed_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      FMT_B: packed_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], in_opcode};
      FMT_U: packed_word = {in_imm[31:12], in_rd, in_opcode};
      FMT_J: packed_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                            in_rd, in_opcode};
      default: packed_word = 32'd0;
    endcase
  end

  // Priority: format, then alignment, then range.
  always_comb begin
    chk_code = 2'd0;
    if (in_fmt > FMT_J) begin
      chk_code = 2'd3;
    end else if (((in_fmt == FMT_B) || (in_fmt == FMT_J)) && in_imm[0]) begin
      chk_code = 2'd2;
    end else if ((in_fmt == FMT_U) && (|in_imm[11:0])) begin
      chk_code = 2'd2;
    end else if (((in_fmt == FMT_I) || (in_fmt == FMT_S)) && !sext_is) begin
      chk_code = 2'd1;
    end else if ((in_fmt == FMT_B) && !sext_b) begin
      chk_code = 2'd1;
    end else if ((in_fmt == FMT_J) && !sext_j) begin
      chk_code = 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      err       <= 1'b0;
      err_code  <= 2'd0;
      count     <= '0;
      full      <= 1'b0;
      wr_ptr    <= PTR_BASE;
    end else begin
      err <= 1'b0;
      if (mem_we && mem_ready) begin
        mem_we <= 1'b0;
      end
      if (accept) begin
        if (chk_code == 2'd0) begin
          // Reload overrides the completion above for back-to-back writes.
          mem_we    <= 1'b1;
          mem_addr  <= wr_ptr;
          mem_wdata <= packed_word;
          wr_ptr    <= wr_ptr + PTR_ONE;
          count     <= count + CNT_ONE;
          if (wr_ptr == '1) begin
            full <= 1'b1;
          end
        end else begin
          err      <= 1'b1;
          err_code <= chk_code;
        end
      end
      // accept is blocked while clear is high, so these never collide with
      // the updates above; the buffered write is left to drain.
      if (clear) begin
        wr_ptr <= PTR_BASE;
        count  <= '0;
        full   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear, s_clear;
  logic        in_valid, s_in_valid;
  logic        in_ready, s_in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        mem_we, s_mem_we;
  logic [7:0]  mem_addr;
  logic [1:0]  s_mem_addr;
  logic [31:0] mem_wdata, s_mem_wdata;
  logic        mem_ready, s_mem_ready;
  logic        err, s_err;
  logic [1:0]  err_code, s_err_code;
  logic [8:0]  count;
  logic [2:0]  s_count;
  logic        full, s_full;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .err(err), .err_code(err_code), .count(count), .full(full)
  );

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(1)) dut_small (
    .clk(clk), .rst(rst), .clear(s_clear), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_ready(s_mem_ready), .err(s_err), .err_code(s_err_code), .count(s_count),
    .full(s_full)
  );

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [1:0]  code;
    logic [31:0] word;
  } vec_t;

  vec_t vt[15];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic set_fields(input vec_t v);
    in_fmt    = v.fmt;
    in_opcode = v.op;
    in_rd     = v.rd;
    in_rs1    = v.rs1;
    in_rs2    = v.rs2;
    in_funct3 = v.f3;
    in_funct7 = v.f7;
    in_imm    = v.imm;
  endtask

  // Error code from the encodable ranges, computed with signed arithmetic.
  function automatic logic [1:0] ref_code(input logic [2:0] f, input logic [31:0] imm);
    int s;
    s = int'(imm);
    if (f > 3'd5) return 2'd3;
    if ((f == 3'd3 || f == 3'd5) && (s % 2 != 0)) return 2'd2;
    if (f == 3'd4 && (imm % 4096) != 0) return 2'd2;
    if ((f == 3'd1 || f == 3'd2) && (s < -2048 || s > 2047)) return 2'd1;
    if (f == 3'd3 && (s < -4096 || s > 4095)) return 2'd1;
    if (f == 3'd5 && (s < -1048576 || s > 1048575)) return 2'd1;
    return 2'd0;
  endfunction

  // The core's immediate generator; for R it returns {funct7, rs2}.
  function automatic logic [31:0] imm_gen(input logic [2:0] f, input logic [31:0] w);
    case (f)
      3'd1:    imm_gen = {{20{w[31]}}, w[31:20]};
      3'd2:    imm_gen = {{20{w[31]}}, w[31:25], w[11:7]};
      3'd3:    imm_gen = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd4:    imm_gen = {w[31:12], 12'b0};
      3'd5:    imm_gen = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: imm_gen = {20'b0, w[31:20]};
    endcase
  endfunction

  logic [7:0]  exp_ptr;
  logic [8:0]  exp_cnt;
  logic [31:0] held_addr, held_word;
  logic        m_busy, m_full, m_rdy, acc;
  logic [1:0]  rcode;
  logic [7:0]  m_ptr;
  logic [8:0]  m_cnt;

  initial begin
    vt[0]  = '{3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFF, 2'd0, 32'hFFF1_0093};
    vt[1]  = '{3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 32'h0000_0800, 2'd1, 32'h0};
    vt[2]  = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_F000, 2'd0, 32'h8000_0063};
    vt[3]  = '{3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0000_0006, 2'd0, 32'h0020_8363};
    vt[4]  = '{3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0000_0003, 2'd2, 32'h0};
    vt[5]  = '{3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0010_0000, 2'd1, 32'h0};
    vt[6]  = '{3'd7, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 32'h0000_0000, 2'd3, 32'h0};
    vt[7]  = '{3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'h1234_5678, 2'd0, 32'h4031_00B3};
    vt[8]  = '{3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'h0000_0008, 2'd0, 32'h0020_A423};
    vt[9]  = '{3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5000, 2'd0, 32'h1234_52B7};
    vt[10] = '{3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5001, 2'd2, 32'h0};
    vt[11] = '{3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0800, 2'd0, 32'h0010_00EF};
    vt[12] = '{3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0003, 2'd2, 32'h0};
    vt[13] = '{3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 32'hFFFF_F800, 2'd0, 32'h8001_0093};
    vt[14] = '{3'd6, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0003, 2'd3, 32'h0};

    rst = 1'b1; clear = 1'b0; s_clear = 1'b0; in_valid = 1'b0; s_in_valid = 1'b0;
    mem_ready = 1'b1; s_mem_ready = 1'b1;
    set_fields(vt[0]);
    repeat (3) step();
    rst = 1'b0;
    step();

    // reset state
    chk("rst_we",       32'(mem_we),    32'd0);
    chk("rst_addr",     32'(mem_addr),  32'd0);
    chk("rst_wdata",    mem_wdata,      32'd0);
    chk("rst_err",      32'(err),       32'd0);
    chk("rst_err_code", 32'(err_code),  32'd0);
    chk("rst_count",    32'(count),     32'd0);
    chk("rst_full",     32'(full),      32'd0);
    chk("rst_in_ready", 32'(in_ready),  32'd1);

    // table vectors
    exp_ptr = 8'd0; exp_cnt = 9'd0;
    for (int i = 0; i < 15; i++) begin
      set_fields(vt[i]);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      if (vt[i].code == 2'd0) begin
        chk($sformatf("vec%0d_we", i),    32'(mem_we),   32'd1);
        chk($sformatf("vec%0d_addr", i),  32'(mem_addr), 32'(exp_ptr));
        chk($sformatf("vec%0d_wdata", i), mem_wdata,     vt[i].word);
        chk($sformatf("vec%0d_err", i),   32'(err),      32'd0);
        exp_ptr++; exp_cnt++;
      end else begin
        chk($sformatf("vec%0d_err", i),  32'(err),      32'd1);
        chk($sformatf("vec%0d_code", i), 32'(err_code), 32'(vt[i].code));
        chk($sformatf("vec%0d_nowr", i), 32'(mem_we),   32'd0);
      end
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(exp_cnt));
      step();
      chk($sformatf("vec%0d_err_pulse", i), 32'(err),    32'd0);
      chk($sformatf("vec%0d_drain", i),     32'(mem_we), 32'd0);
    end

    // backpressure then back-to-back
    mem_ready = 1'b0;
    set_fields(vt[8]);
    in_valid = 1'b1;
    step();
    chk("bp_we",    32'(mem_we),   32'd1);
    chk("bp_addr",  32'(mem_addr), 32'(exp_ptr));
    chk("bp_wdata", mem_wdata,     vt[8].word);
    held_addr = 32'(mem_addr); held_word = mem_wdata;
    set_fields(vt[9]);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_in_ready_%0d", k), 32'(in_ready), 32'd0);
      step();
      chk($sformatf("bp_addr_stable_%0d", k),  32'(mem_addr), held_addr);
      chk($sformatf("bp_wdata_stable_%0d", k), mem_wdata,     held_word);
      chk($sformatf("bp_we_held_%0d", k),      32'(mem_we),   32'd1);
    end
    mem_ready = 1'b1;
    step();
    chk("b2b_addr1",  32'(mem_addr), 32'(exp_ptr + 8'd1));
    chk("b2b_wdata1", mem_wdata,     vt[9].word);
    set_fields(vt[11]);
    step();
    chk("b2b_addr2",  32'(mem_addr), 32'(exp_ptr + 8'd2));
    chk("b2b_wdata2", mem_wdata,     vt[11].word);
    in_valid = 1'b0;
    step();
    chk("b2b_drain", 32'(mem_we), 32'd0);
    exp_ptr = exp_ptr + 8'd3; exp_cnt = exp_cnt + 9'd3;
    chk("b2b_count", 32'(count), 32'(exp_cnt));

    // clear with a write pending
    mem_ready = 1'b0;
    set_fields(vt[0]);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_pend_we",    32'(mem_we),   32'd1);
    chk("clr_pend_addr",  32'(mem_addr), 32'(exp_ptr));
    chk("clr_pend_wdata", mem_wdata,     vt[0].word);
    chk("clr_count",      32'(count),    32'd0);
    mem_ready = 1'b1;
    step();
    chk("clr_pend_done", 32'(mem_we), 32'd0);
    // clear and in_valid on the same edge
    clear = 1'b1; in_valid = 1'b1;
    #1;
    chk("clr_in_ready", 32'(in_ready), 32'd0);
    step();
    clear = 1'b0; in_valid = 1'b0;
    chk("clr_valid_noacc_we",    32'(mem_we), 32'd0);
    chk("clr_valid_noacc_count", 32'(count),  32'd0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("clr_next_addr",  32'(mem_addr), 32'd0);
    chk("clr_next_count", 32'(count),    32'd1);
    step();

    // full/wrap on the ADDR_W=2, BASE_ADDR=1 instance
    set_fields(vt[3]);
    s_in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("full_addr_%0d", k),  32'(s_mem_addr), 32'(k + 1));
      chk($sformatf("full_wdata_%0d", k), s_mem_wdata,     vt[3].word);
    end
    chk("full_flag",     32'(s_full),     32'd1);
    chk("full_in_ready", 32'(s_in_ready), 32'd0);
    chk("full_count",    32'(s_count),    32'd3);
    step();
    chk("full_noacc_we",    32'(s_mem_we), 32'd0);
    chk("full_noacc_count", 32'(s_count),  32'd3);
    s_in_valid = 1'b0;
    s_clear = 1'b1;
    step();
    s_clear = 1'b0;
    chk("full_clr_flag", 32'(s_full), 32'd0);
    s_in_valid = 1'b1;
    step();
    s_in_valid = 1'b0;
    chk("full_clr_addr",  32'(s_mem_addr), 32'd1);
    chk("full_clr_count", 32'(s_count),    32'd1);
    step();

    // reset drops a pending write
    mem_ready = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("rstmid_pend", 32'(mem_we), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid_we",    32'(mem_we), 32'd0);
    chk("rstmid_count", 32'(count),  32'd0);

    // random stimulus against the reference model
    m_busy = 1'b0; m_full = 1'b0; m_ptr = 8'd0; m_cnt = 9'd0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) in_fmt = 3'($urandom_range(6, 7));
      else in_fmt = 3'($urandom_range(0, 5));
      in_opcode = 7'($urandom); in_rd = 5'($urandom); in_rs1 = 5'($urandom);
      in_rs2 = 5'($urandom); in_funct3 = 3'($urandom); in_funct7 = 7'($urandom);
      case (in_fmt)
        3'd1, 3'd2: in_imm = $urandom_range(0, 4095) - 32'd2048;
        3'd3:       in_imm = ($urandom_range(0, 4095) - 32'd2048) * 2;
        3'd4:       in_imm = $urandom & 32'hFFFF_F000;
        3'd5:       in_imm = ($urandom_range(0, 1048575) - 32'd524288) * 2;
        default:    in_imm = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) in_imm = $urandom;
      in_valid  = ($urandom_range(0, 9) < 7);
      mem_ready = ($urandom_range(0, 9) < 6);
      #1;
      m_rdy = !m_full && (!m_busy || mem_ready);
      chk("rnd_in_ready", 32'(in_ready), 32'(m_rdy));
      acc   = in_valid && m_rdy;
      rcode = ref_code(in_fmt, in_imm);
      if (m_busy && mem_ready) m_busy = 1'b0;
      step();
      if (acc && rcode == 2'd0) begin
        chk("rnd_addr", 32'(mem_addr), 32'(m_ptr));
        chk("rnd_imm", imm_gen(in_fmt, mem_wdata),
            (in_fmt == 3'd0) ? {20'b0, in_funct7, in_rs2} : in_imm);
        chk("rnd_opcode", 32'(mem_wdata[6:0]), 32'(in_opcode));
        chk("rnd_err", 32'(err), 32'd0);
        m_busy = 1'b1;
        if (m_ptr == 8'hFF) m_full = 1'b1;
        m_ptr++; m_cnt++;
      end else if (acc) begin
        chk("rnd_err", 32'(err), 32'd1);
        chk("rnd_err_code", 32'(err_code), 32'(rcode));
      end else begin
        chk("rnd_err", 32'(err), 32'd0);
      end
      chk("rnd_we",    32'(mem_we), 32'(m_busy));
      chk("rnd_count", 32'(count),  32'(m_cnt));
      chk("rnd_full",  32'(full),   32'(m_full));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
